// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared mode codes and FSM state type for the systolic array front end
package systolic_pkg;

    // PE mode_ctrl encodings shared by the feeder and every PE
    localparam logic [1:0] MODE_IDLE    = 2'b00;
    localparam logic [1:0] MODE_LOAD    = 2'b01;
    localparam logic [1:0] MODE_COMPUTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD_W  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DRAIN   = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - enabled shift register that delays one activation row by DEPTH advances
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift one stage per enabled cycle; the line holds its contents when not enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_en) begin
            r_stage[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - loads weights, skews activations and drains the weight-stationary array
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_ROWS = 4,
    parameter int ARRAY_COLS = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             w_valid,
    output logic                             w_ready,
    input  logic [ARRAY_COLS*DATA_WIDTH-1:0] w_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_ROWS*DATA_WIDTH-1:0] in_data,
    input  logic                             in_last,
    output logic [1:0]                       mode_ctrl,
    output logic [ARRAY_COLS*DATA_WIDTH-1:0] col_weight_out,
    output logic [ARRAY_ROWS*DATA_WIDTH-1:0] row_data_out,
    output logic                             busy,
    output logic                             done
);

    // One counter serves both the weight-beat count and the drain length
    localparam int CNT_W = $clog2(ARRAY_ROWS + ARRAY_COLS);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ARRAY_ROWS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ARRAY_ROWS + ARRAY_COLS - 2);

    feeder_state_e                    r_state;
    logic [CNT_W-1:0]                 r_cnt;
    logic [1:0]                       r_mode;
    logic [ARRAY_COLS*DATA_WIDTH-1:0] r_col_weight;
    logic [ARRAY_ROWS*DATA_WIDTH-1:0] r_row_data;
    logic                             r_drain_end;
    logic                             r_done;

    logic                  w_wt_acc;
    logic                  w_in_acc;
    logic                  w_drain;
    logic                  w_adv;
    logic [DATA_WIDTH-1:0] w_skew_in  [ARRAY_ROWS];
    logic [DATA_WIDTH-1:0] w_skew_out [ARRAY_ROWS];

    assign w_wt_acc = w_valid  && (r_state == ST_LOAD_W);
    assign w_in_acc = in_valid && (r_state == ST_COMPUTE);
    assign w_drain  = (r_state == ST_DRAIN);
    // Skew lines move only on real data or drain zeros, so bubbles freeze the wavefront
    assign w_adv    = w_in_acc || w_drain;

    generate
        for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
            assign w_skew_in[r] = w_drain ? '0 : in_data[r*DATA_WIDTH +: DATA_WIDTH];
            if (r == 0) begin : g_direct
                assign w_skew_out[r] = w_skew_in[r];
            end else begin : g_skew
                skew_line #(
                    .DEPTH (r),
                    .WIDTH (DATA_WIDTH)
                ) u_skew (
                    .clk    (clk),
                    .rst    (rst),
                    .i_en   (w_adv),
                    .i_data (w_skew_in[r]),
                    .o_data (w_skew_out[r])
                );
            end
        end
    endgenerate

    // Control FSM with registered mode, weight, row data and done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_mode       <= MODE_IDLE;
            r_col_weight <= '0;
            r_row_data   <= '0;
            r_drain_end  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_mode      <= MODE_IDLE;
            r_drain_end <= 1'b0;
            // done trails the last drain cycle by one so it lands on the first idle mode cycle
            r_done      <= r_drain_end;
            if (w_adv) begin
                for (int r = 0; r < ARRAY_ROWS; r++) begin
                    r_row_data[r*DATA_WIDTH +: DATA_WIDTH] <= w_skew_out[r];
                end
            end
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_valid) begin
                        r_state <= ST_LOAD_W;
                    end else if (in_valid) begin
                        r_state <= ST_COMPUTE;
                    end
                end
                ST_LOAD_W: begin
                    if (w_wt_acc) begin
                        r_col_weight <= w_data;
                        r_mode       <= MODE_LOAD;
                        if (r_cnt == LOAD_LAST) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (w_in_acc) begin
                        r_mode <= MODE_COMPUTE;
                        if (in_last) begin
                            r_cnt   <= '0;
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_mode <= MODE_COMPUTE;
                    if (r_cnt == DRAIN_LAST) begin
                        r_cnt       <= '0;
                        r_state     <= ST_IDLE;
                        r_drain_end <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_ready        = (r_state == ST_LOAD_W);
    assign in_ready       = (r_state == ST_COMPUTE);
    assign busy           = (r_state != ST_IDLE);
    assign mode_ctrl      = r_mode;
    assign col_weight_out = r_col_weight;
    assign row_data_out   = r_row_data;
    assign done           = r_done;

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - scoreboard bench for systolic_feeder
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int NC = 4;
    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_L = 2'd1;
    localparam logic [1:0] S_C = 2'd2;
    localparam logic [1:0] S_D = 2'd3;
    localparam int A_NONE  = 0;
    localparam int A_ACC   = 1;
    localparam int A_DRAIN = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_valid = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] w_data = '0;
    logic [31:0] in_data = '0;
    logic        w_ready, in_ready, busy, done;
    logic [1:0]  mode_ctrl;
    logic [31:0] col_weight_out, row_data_out;

    int total = 0;
    int bad = 0;

    logic [69:0] exp_q [$];
    logic [69:0] obs_q [$];
    logic [31:0] m_wgt = '0;
    logic [31:0] m_hist [NR];

    always #5 clk = ~clk;

    systolic_feeder #(.DATA_WIDTH(DW), .ARRAY_ROWS(NR), .ARRAY_COLS(NC)) dut (
        .clk            (clk),
        .rst            (rst),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .mode_ctrl      (mode_ctrl),
        .col_weight_out (col_weight_out),
        .row_data_out   (row_data_out),
        .busy           (busy),
        .done           (done)
    );

    // Drive one cycle, push the expected outputs for the next cycle, capture what the DUT shows
    task automatic step(input logic rs, input logic wv, input logic [31:0] wd,
                        input logic iv, input logic [31:0] id, input logic il,
                        input logic [1:0] em, input logic ew, input int adv,
                        input logic ed, input logic [1:0] est);
        logic [31:0] e_row;
        rst = rs; w_valid = wv; w_data = wd; in_valid = iv; in_data = id; in_last = il;
        if (rs) begin
            m_wgt = '0;
            for (int r = 0; r < NR; r++) m_hist[r] = '0;
        end else begin
            if (ew) m_wgt = wd;
            if (adv != A_NONE) begin
                for (int r = NR - 1; r > 0; r--) m_hist[r] = m_hist[r-1];
                m_hist[0] = (adv == A_ACC) ? id : 32'h0;
            end
        end
        for (int r = 0; r < NR; r++) e_row[r*DW +: DW] = m_hist[r][r*DW +: DW];
        if (rs) exp_q.push_back(70'h0);
        else exp_q.push_back({em, m_wgt, e_row, ed, est != S_I, est == S_L, est == S_C});
        @(posedge clk);
        #1;
        obs_q.push_back({mode_ctrl, col_weight_out, row_data_out, done, busy, w_ready, in_ready});
    endtask

    task automatic idle_step(input logic ed);
        step(0, 0, 0, 0, 0, 0, MODE_IDLE, 0, A_NONE, ed, S_I);
    endtask

    // Seven zero-injecting drain cycles followed by the done cycle and one quiet cycle
    task automatic drain_and_done();
        for (int k = 0; k < NR + NC - 1; k++)
            step(0, 0, 0, 0, 0, 0, MODE_COMPUTE, 0, A_DRAIN, 0, (k == NR + NC - 2) ? S_I : S_D);
        idle_step(1);
        idle_step(0);
    endtask

    task automatic single_job(input logic [31:0] v);
        step(0, 0, 0, 1, v, 1, MODE_IDLE, 0, A_NONE, 0, S_C);
        step(0, 0, 0, 1, v, 1, MODE_COMPUTE, 0, A_ACC, 0, S_D);
        drain_and_done();
    endtask

    task automatic test_reset();
        int n = 0;
        logic [69:0] e, o;
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 0, MODE_IDLE, 0, A_NONE, 0, S_I);
        step(0, 1, 32'h11111111, 0, 0, 0, MODE_IDLE, 0, A_NONE, 0, S_L);
        step(0, 1, 32'h11111111, 0, 0, 0, MODE_LOAD, 1, A_NONE, 0, S_L);
        step(0, 1, 32'h22222222, 0, 0, 0, MODE_LOAD, 1, A_NONE, 0, S_L);
        for (int k = 0; k < 3; k++) step(1, 1, 32'h33333333, 0, 0, 0, MODE_IDLE, 0, A_NONE, 0, S_I);
        idle_step(0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL reset cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
    endtask

    task automatic test_weight_load();
        int n = 0;
        logic [69:0] e, o;
        logic [31:0] beats [4];
        beats[0] = 32'h04030201; beats[1] = 32'h08070605;
        beats[2] = 32'h0C0B0A09; beats[3] = 32'h100F0E0D;
        step(0, 1, beats[0], 0, 0, 0, MODE_IDLE, 0, A_NONE, 0, S_L);
        for (int k = 0; k < 4; k++)
            step(0, 1, beats[k], 0, 0, 0, MODE_LOAD, 1, A_NONE, 0, (k == 3) ? S_I : S_L);
        idle_step(0);
        idle_step(0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL weight_load cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
    endtask

    task automatic test_single_vector();
        int n = 0;
        logic [69:0] e, o;
        single_job(32'h04030201);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL single_vector cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
    endtask

    task automatic test_bubbles();
        int n = 0;
        logic [69:0] e, o;
        step(0, 0, 0, 1, 32'h44332211, 0, MODE_IDLE, 0, A_NONE, 0, S_C);
        step(0, 0, 0, 1, 32'h44332211, 0, MODE_COMPUTE, 0, A_ACC, 0, S_C);
        step(0, 0, 0, 0, 32'hFFFFFFFF, 0, MODE_IDLE, 0, A_NONE, 0, S_C);
        step(0, 0, 0, 0, 32'hFFFFFFFF, 1, MODE_IDLE, 0, A_NONE, 0, S_C);
        step(0, 0, 0, 1, 32'h88776655, 0, MODE_COMPUTE, 0, A_ACC, 0, S_C);
        step(0, 0, 0, 1, 32'hCCBBAA99, 1, MODE_COMPUTE, 0, A_ACC, 0, S_D);
        drain_and_done();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL bubbles cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
    endtask

    task automatic test_priority();
        int n = 0;
        logic [69:0] e, o;
        logic [31:0] v;
        v = 32'hA4A3A2A1;
        step(0, 1, 32'h0000F001, 1, v, 1, MODE_IDLE, 0, A_NONE, 0, S_L);
        for (int k = 0; k < 4; k++)
            step(0, 1, 32'h0000F001 + k, 1, v, 1, MODE_LOAD, 1, A_NONE, 0, (k == 3) ? S_I : S_L);
        step(0, 0, 0, 1, v, 1, MODE_IDLE, 0, A_NONE, 0, S_C);
        step(0, 0, 0, 1, v, 1, MODE_COMPUTE, 0, A_ACC, 0, S_D);
        drain_and_done();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL priority cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
    endtask

    task automatic test_drain_reset();
        int n = 0;
        logic [69:0] e, o;
        step(0, 0, 0, 1, 32'h5A5B5C5D, 1, MODE_IDLE, 0, A_NONE, 0, S_C);
        step(0, 0, 0, 1, 32'h5A5B5C5D, 1, MODE_COMPUTE, 0, A_ACC, 0, S_D);
        step(0, 0, 0, 0, 0, 0, MODE_COMPUTE, 0, A_DRAIN, 0, S_D);
        step(0, 0, 0, 0, 0, 0, MODE_COMPUTE, 0, A_DRAIN, 0, S_D);
        step(1, 0, 0, 0, 0, 0, MODE_IDLE, 0, A_NONE, 0, S_I);
        for (int k = 0; k < NR + NC; k++) idle_step(0);
        single_job(32'hDEADBEEF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
            if (o !== e) begin bad++; $display("FAIL drain_reset cyc=%0d got=%h exp=%h", n, o, e); end
            n++;
        end
    endtask

    initial begin
        for (int r = 0; r < NR; r++) m_hist[r] = '0;
        test_reset();
        test_weight_load();
        test_single_vector();
        test_bubbles();
        test_priority();
        test_drain_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Front-end stage of the weight-stationary systolic array: accepts weight vectors and activation vectors over valid/ready streams and drives the array's `mode_ctrl`, top-edge weight inputs and left-edge data inputs. Weights are shifted down the columns during load; activations are diagonally skewed so that row r receives its element r cycles after row 0. After the last activation it flushes the array with zeros so every partial sum reaches the bottom edge. It drives every PE's `mode_ctrl`, `weight_in` (top row) and `data_in` (column 0) directly.

## Interface
- `DATA_WIDTH`, 8, element width; matches the PE
- `ARRAY_ROWS`, 4, PE rows (reduction dimension); ≥ 2
- `ARRAY_COLS`, 4, PE columns; ≥ 1
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; one clock, reset is synchronous and active-high
- `w_valid`  in  1  weight beat valid
- `w_ready`  out  1  weight beat accepted when `w_valid & w_ready`
- `w_data`  in  ARRAY_COLS*DATA_WIDTH  one weight row; column c at `[c*DATA_WIDTH +: DATA_WIDTH]`
- `in_valid`  in  1  activation beat valid
- `in_ready`  out  1  activation beat accepted when `in_valid & in_ready`
- `in_data`  in  ARRAY_ROWS*DATA_WIDTH  one activation vector; row r at `[r*DATA_WIDTH +: DATA_WIDTH]`
- `in_last`  in  1  marks final activation beat of a job
- `mode_ctrl`  out  2  to all PEs: 00 idle/freeze, 01 load weight, 10 compute
- `col_weight_out`  out  ARRAY_COLS*DATA_WIDTH  to top-row `weight_in`
- `row_data_out`  out  ARRAY_ROWS*DATA_WIDTH  to column-0 `data_in`
- `busy`  out  1  FSM not in IDLE
- `done`  out  1  one-cycle pulse when a job's drain completes

## Operation
- FSM states: IDLE, LOAD_W, COMPUTE, DRAIN. `w_ready` = 1 only in LOAD_W; `in_ready` = 1 only in COMPUTE.
- IDLE: if `w_valid` → LOAD_W, else if `in_valid` → COMPUTE. Weight has priority when both are valid. No beat is accepted in the transition cycle.
- LOAD_W: each accepted beat is registered to `col_weight_out` with `mode_ctrl` = 01 on the next cycle. A cycle with no accepted beat gives `mode_ctrl` = 00, which freezes the array.
  - Beat count counts to ARRAY_ROWS, then → IDLE.
  - The first beat ends up in the bottom row, so the source sends the bottom row first.
- COMPUTE: each accepted beat advances the skew lines and outputs `mode_ctrl` = 10 on the next cycle. Bubble cycles give `mode_ctrl` = 00, and the skew lines and `row_data_out` hold.
  - Accepted beat with `in_last` → DRAIN.
- Skew: row r output equals the row r element accepted r advances earlier. Row 0 has only the output register. Skew registers advance only on an accepted beat or a drain cycle.
- DRAIN: ARRAY_ROWS+ARRAY_COLS-1 cycles, never stalls. Zeros are injected at the skew-line inputs and `mode_ctrl` = 10. Then → IDLE and `done` = 1 for one cycle.
- `in_last` on the first beat is legal: a job of one vector.
- No arithmetic. Data passes through unmodified at full `DATA_WIDTH`.

## Timing
- Reset values: `mode_ctrl` 00, `col_weight_out` 0, `row_data_out` 0, `w_ready` 0, `in_ready` 0, `busy` 0, `done` 0. Skew registers and counters are 0 and the FSM is in IDLE.
- All outputs are registered except `w_ready`, `in_ready` and `busy`, which are decoded from the state register.
- Latency: a beat accepted in cycle t appears with its `mode_ctrl` at t+1. Row r of that beat appears at row r's output on the r-th advance after t+1.
- Back-to-back beats give consecutive mode-01 or mode-10 cycles with no gap.
- `rst` asserted in any state, including mid-load or mid-drain: the next cycle shows reset values, no `done` pulse, and any partial job is discarded.
- `done` coincides with the first `mode_ctrl` = 00 cycle after drain.

## Structure
- Shared package `systolic_pkg`:
  - mode constants `MODE_IDLE` = 2'b00, `MODE_LOAD` = 2'b01, `MODE_COMPUTE` = 2'b10
  - FSM state enum
- Sub-module `skew_line`: an enabled shift register with parameters depth and width, synchronous active-high clear. The feeder instantiates one per row r ≥ 1, with depth r.

## Test plan
All cases use DATA_WIDTH=8, ROWS=COLS=4.
- Reset: hold `rst` 3 cycles mid-stream → all outputs zero and `mode_ctrl`=00 on the cycle after `rst` is sampled.
- Weight load: 4 back-to-back beats 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D → `mode_ctrl`=01 for exactly 4 cycles with `col_weight_out` showing the beats in order, then 00; `w_ready` low after the 4th beat.
- Single vector: `in_data`={8'h04,8'h03,8'h02,8'h01} with `in_last` accepted at t → row0=01 at t+1, row1=02 at t+2, row2=03 at t+3, row3=04 at t+4; `mode_ctrl`=10 for cycles t+1..t+8; `done` at t+9.
- Bubbles: `in_valid` dropped for 2 cycles between beats → `mode_ctrl`=00 for 2 cycles, `row_data_out` unchanged, skew resumes correctly afterwards.
- Priority: `w_valid` and `in_valid` high together in IDLE → LOAD_W entered first; COMPUTE starts only after 4 weight beats.
- Reset in the 3rd drain cycle → no `done`, reset values; a new job afterwards runs normally.
